// File: rtl/cfg_mgmt_pkg.sv
// cfg_mgmt_pkg: shared types and constants for the cfg_mgmt bridge.
// Used by cfg_mgmt_bridge (optional timeout: CFG_MGMT_TIMEOUT_EN).
package cfg_mgmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } cfg_state_t;

    localparam logic [15:0] TIMEOUT_CYCLES_DEF = 16'd1024;
    localparam logic [31:0] ERR_RD_DATA        = 32'hFFFF_FFFF;
    localparam logic [15:0] DROP_MAX           = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == DROP_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cfg_mgmt_bridge.sv
// cfg_mgmt_bridge: CSR-stage request pulses to the core cfg_mgmt port.
// Optional ACCESS timeout compiled in with `define CFG_MGMT_TIMEOUT_EN.
module cfg_mgmt_bridge
    import cfg_mgmt_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int          ADDR_W         = 19
) (
    input  logic              user_clk,
    input  logic              user_reset_n,
    input  logic              req_write,
    input  logic              req_read,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wr_data,
    input  logic [3:0]        req_byte_enable,
    input  logic              req_type1,
    output logic              busy,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rd_data,
    output logic              rsp_timeout,
    output logic [15:0]       drop_count,
    output logic [ADDR_W-1:0] cfg_mgmt_addr,
    output logic              cfg_mgmt_write,
    output logic              cfg_mgmt_read,
    output logic [31:0]       cfg_mgmt_write_data,
    output logic [3:0]        cfg_mgmt_byte_enable,
    output logic              cfg_mgmt_type1_cfg_reg_access,
    input  logic [31:0]       cfg_mgmt_read_data,
    input  logic              cfg_mgmt_read_write_done
);

    cfg_state_t        r_state;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rd_data;
    logic [15:0]       r_drop_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic              r_rd;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_type1;

    logic              w_req;
    logic              w_unused;

    assign w_req    = req_write | req_read;
    assign w_unused = ^{TIMEOUT_CYCLES, req_addr};

`ifdef CFG_MGMT_TIMEOUT_EN
    logic [15:0] r_wait;
    logic        r_rsp_timeout;
    logic        w_expire;

    // r_wait counts ACCESS cycles already spent without done
    assign w_expire    = (r_wait == TIMEOUT_CYCLES - 16'd1);
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rd_data <= '0;
            r_drop_count  <= '0;
            r_addr        <= '0;
            r_wr          <= 1'b0;
            r_rd          <= 1'b0;
            r_wdata       <= '0;
            r_be          <= '0;
            r_type1       <= 1'b0;
`ifdef CFG_MGMT_TIMEOUT_EN
            r_wait        <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_req && r_busy)
                r_drop_count <= sat_inc16(r_drop_count);

            unique case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= req_addr[ADDR_W-1:0];
                        r_wdata <= req_wr_data;
                        r_be    <= req_byte_enable;
                        r_type1 <= req_type1;
                        // write wins when both pulses coincide
                        r_wr    <= req_write;
                        r_rd    <= ~req_write;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCESS;
`ifdef CFG_MGMT_TIMEOUT_EN
                        r_wait  <= '0;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (cfg_mgmt_read_write_done) begin
                        r_wr        <= 1'b0;
                        r_rd        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                        if (r_rd)
                            r_rsp_rd_data <= cfg_mgmt_read_data;
                    end
`ifdef CFG_MGMT_TIMEOUT_EN
                    else if (w_expire) begin
                        r_wr          <= 1'b0;
                        r_rd          <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_RESP;
                        if (r_rd)
                            r_rsp_rd_data <= ERR_RD_DATA;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
`endif
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef CFG_MGMT_TIMEOUT_EN
                    r_rsp_timeout <= 1'b0;
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_wr    <= 1'b0;
                    r_rd    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy                          = r_busy;
    assign rsp_valid                     = r_rsp_valid;
    assign rsp_rd_data                   = r_rsp_rd_data;
    assign drop_count                    = r_drop_count;
    assign cfg_mgmt_addr                 = r_addr;
    assign cfg_mgmt_write                = r_wr;
    assign cfg_mgmt_read                 = r_rd;
    assign cfg_mgmt_write_data           = r_wdata;
    assign cfg_mgmt_byte_enable          = r_be;
    assign cfg_mgmt_type1_cfg_reg_access = r_type1;

endmodule

// File: tb/tb_cfg_mgmt_bridge.sv
// tb_cfg_mgmt_bridge: directed + random checks of cfg_mgmt_bridge
// against a transaction-level model (CFG_MGMT_TIMEOUT_EN aware).
module tb_cfg_mgmt_bridge;

    localparam int ADDR_W = 19;
`ifdef CFG_MGMT_TIMEOUT_EN
    localparam logic [15:0] TMO    = 16'd8;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam logic [15:0] TMO    = 16'd1024;
    localparam bit          TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              req_write = 1'b0;
    logic              req_read = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wr_data = '0;
    logic [3:0]        req_be = '0;
    logic              req_type1 = 1'b0;
    logic              busy;
    logic              rsp_valid;
    logic [31:0]       rsp_rd_data;
    logic              rsp_timeout;
    logic [15:0]       drop_count;
    logic [ADDR_W-1:0] m_addr;
    logic              m_wr;
    logic              m_rd;
    logic [31:0]       m_wdata;
    logic [3:0]        m_be;
    logic              m_t1;
    logic [31:0]       m_rdata = '0;
    logic              m_done = 1'b0;

    cfg_mgmt_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .ADDR_W        (ADDR_W)
    ) dut (
        .user_clk                     (clk),
        .user_reset_n                 (rst_n),
        .req_write                    (req_write),
        .req_read                     (req_read),
        .req_addr                     (req_addr),
        .req_wr_data                  (req_wr_data),
        .req_byte_enable              (req_be),
        .req_type1                    (req_type1),
        .busy                         (busy),
        .rsp_valid                    (rsp_valid),
        .rsp_rd_data                  (rsp_rd_data),
        .rsp_timeout                  (rsp_timeout),
        .drop_count                   (drop_count),
        .cfg_mgmt_addr                (m_addr),
        .cfg_mgmt_write               (m_wr),
        .cfg_mgmt_read                (m_rd),
        .cfg_mgmt_write_data          (m_wdata),
        .cfg_mgmt_byte_enable         (m_be),
        .cfg_mgmt_type1_cfg_reg_access(m_t1),
        .cfg_mgmt_read_data           (m_rdata),
        .cfg_mgmt_read_write_done     (m_done)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cnt_wr = 0;
    int cnt_rd = 0;
    int cnt_v = 0;
    int cnt_tmo = 0;

    // model: one outstanding transaction, either waiting or responding
    bit          o_out;
    bit          o_resp;
    bit          o_tmo;
    int          o_wait;
    bit          t_wr;
    logic [31:0] t_addr;
    logic [31:0] t_data;
    logic [3:0]  t_be;
    bit          t_t1;
    logic [31:0] o_rd;
    int          o_drops;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        o_out = 0; o_resp = 0; o_tmo = 0; o_wait = 0;
        t_wr = 0; t_addr = '0; t_data = '0; t_be = '0; t_t1 = 0;
        o_rd = '0; o_drops = 0;
    endtask

    task automatic model_edge();
        bit req;
        req = req_write | req_read;
        if (!o_out) begin
            if (req) begin
                o_out = 1; o_resp = 0; o_tmo = 0; o_wait = 0;
                t_wr = req_write; t_addr = req_addr; t_data = req_wr_data;
                t_be = req_be; t_t1 = req_type1;
            end
        end else begin
            if (req && o_drops < 65535) o_drops++;
            if (o_resp) begin
                o_out = 0;
            end else if (m_done) begin
                if (!t_wr) o_rd = m_rdata;
                o_resp = 1;
            end else begin
                o_wait++;
                if (TMO_EN && o_wait == int'(TMO)) begin
                    if (!t_wr) o_rd = 32'hFFFF_FFFF;
                    o_tmo = 1;
                    o_resp = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit acc;
        acc = o_out && !o_resp;
        chk("busy", 32'(busy), 32'(o_out));
        chk("wr_strobe", 32'(m_wr), 32'(acc && t_wr));
        chk("rd_strobe", 32'(m_rd), 32'(acc && !t_wr));
        chk("rsp_valid", 32'(rsp_valid), 32'(o_out && o_resp));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(o_out && o_resp && o_tmo));
        chk("rsp_rd_data", rsp_rd_data, o_rd);
        chk("drop_count", 32'(drop_count), 32'(o_drops));
        chk("addr", 32'(m_addr), 32'(t_addr[ADDR_W-1:0]));
        chk("wdata", m_wdata, t_data);
        chk("be", 32'(m_be), 32'(t_be));
        chk("type1", 32'(m_t1), 32'(t_t1));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
        if (m_wr) cnt_wr++;
        if (m_rd) cnt_rd++;
        if (rsp_valid) cnt_v++;
        if (rsp_timeout) cnt_tmo++;
    endtask

    task automatic issue(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input bit t1);
        req_write = w; req_read = r; req_addr = a;
        req_wr_data = d; req_be = be; req_type1 = t1;
        cycle();
        req_write = 0; req_read = 0;
    endtask

    task automatic clr_cnt();
        cnt_wr = 0; cnt_rd = 0; cnt_v = 0; cnt_tmo = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        #2 rst_n = 1'b1;
        cycle();

        // write, done in second ACCESS cycle
        clr_cnt();
        issue(1, 0, 32'h0000_0004, 32'h0000_0007, 4'hF, 0);
        chk("w039_addr", 32'(m_addr), 32'h4);
        chk("w039_data", m_wdata, 32'h7);
        cycle();
        m_done = 1; cycle();
        m_done = 0; cycle();
        cycle();
        chk("w039_strobe_cycles", cnt_wr, 2);
        chk("w039_valid_count", cnt_v, 1);
        chk("w039_timeout", cnt_tmo, 0);

        // read, done in first ACCESS cycle -> rsp_valid two edges later
        clr_cnt();
        issue(0, 1, 32'h0000_0000, 32'h0, 4'h0, 0);
        m_done = 1; m_rdata = 32'h1234_10EE; cycle();
        chk("r040_valid", 32'(rsp_valid), 32'd1);
        chk("r040_data", rsp_rd_data, 32'h1234_10EE);
        m_done = 0; m_rdata = 32'hDEAD_BEEF; cycle();
        cycle();
        chk("r040_held", rsp_rd_data, 32'h1234_10EE);

        // overlap drop, then accept in first idle cycle
        issue(1, 0, 32'h10, 32'hA5A5_0001, 4'h3, 1);
        req_read = 1; m_done = 1; cycle();
        req_read = 0; m_done = 0;
        chk("d041_drop", 32'(drop_count), 32'd1);
        cycle();
        chk("d041_idle", 32'(busy), 32'd0);
        issue(0, 1, 32'h20, 32'h0, 4'h0, 0);
        chk("d041_accept", 32'(m_rd), 32'd1);
        m_done = 1; m_rdata = 32'h0BAD_F00D; cycle();
        m_done = 0; cycle();

        // simultaneous write + read pulses
        issue(1, 1, 32'h0007_FFFC, 32'h5555_AAAA, 4'hC, 0);
        chk("b042_wr", 32'(m_wr), 32'd1);
        chk("b042_rd", 32'(m_rd), 32'd0);
        chk("b042_drop", 32'(drop_count), 32'd1);
        m_done = 1; cycle();
        m_done = 0; cycle();

`ifdef CFG_MGMT_TIMEOUT_EN
        clr_cnt();
        issue(0, 1, 32'h44, 32'h0, 4'h0, 0);
        repeat (12) cycle();
        chk("t043_strobe_cycles", cnt_rd, 8);
        chk("t043_timeout", cnt_tmo, 1);
        chk("t043_data", rsp_rd_data, 32'hFFFF_FFFF);
`endif

        // reset in the middle of ACCESS
        issue(0, 1, 32'h80, 32'h0, 4'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("r044_rd", 32'(m_rd), 32'd0);
        chk("r044_busy", 32'(busy), 32'd0);
        cycle();
        #2 rst_n = 1'b1;
        cycle();
        clr_cnt();
        issue(1, 0, 32'h8, 32'h0000_00C3, 4'h1, 0);
        m_done = 1; cycle();
        m_done = 0; cycle();
        cycle();
        chk("r044_valid_count", cnt_v, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin req_write = 1; req_read = 0; end
                    1: begin req_write = 0; req_read = 1; end
                    default: begin req_write = 1; req_read = 1; end
                endcase
            end else begin
                req_write = 0; req_read = 0;
            end
            req_addr = $urandom;
            req_wr_data = $urandom;
            req_be = 4'($urandom);
            req_type1 = 1'($urandom);
            m_rdata = $urandom;
            m_done = TMO_EN ? ($urandom_range(0, 11) == 0)
                            : ($urandom_range(0, 2) == 0);
            cycle();
        end
        req_write = 0; req_read = 0; m_done = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
